// File: rtl/bitonic_sort_seq.sv
`default_nettype none
// ============================================================================
//  Module   : bitonic_sort_seq
//  Purpose  : Sequenced 8-entry bitonic sorter. Eight values are collected
//             over a valid/ready stream and sorted in place by one shared
//             layer of four compare-exchange units. That layer is stepped
//             through the six bitonic layers, one layer per clock, and the
//             result is then streamed out.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DATA_W     width of each value (unsigned compare)
//    ASCEND     1: smallest value first, 0: largest value first
//  Ports
//    clk        clock, all state on the rising edge
//    rst_n      asynchronous active-low reset
//    in_valid   input beat valid
//    in_data    input value
//    in_ready   block accepts an input beat (LOAD)
//    out_valid  output beat valid (DRAIN)
//    out_data   sorted value, zero when out_valid is low
//    out_ready  sink accepts the output beat
//    out_last   high with out_valid on the 8th output beat
//    busy       a batch is in progress
// ============================================================================
module bitonic_sort_seq #(
    parameter int DATA_W = 8,
    parameter bit ASCEND = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_SORT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [2:0] c_LAST_IDX  = 3'd7;
    localparam logic [2:0] c_LAST_LAY  = 3'd5;

    state_t            r_state;
    state_t            w_state_next;
    logic [DATA_W-1:0] r_data [0:7];
    logic [DATA_W-1:0] w_sorted [0:7];
    logic [2:0]        r_cnt;
    logic [2:0]        r_lay;
    logic [2:0]        w_idx_a [0:3];
    logic [2:0]        w_idx_b [0:3];
    logic [2:0]        w_rd_idx;

    // Pair selection for the shared comparator row. Layers 0, 2 and 5 all use
    // the adjacent pairing; 1 and 3 are the mirrored (flip) stages; 4 is the
    // distance-2 half cleaner.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_idx_a[k] = 3'(2 * k);
            w_idx_b[k] = 3'(2 * k + 1);
        end
        case (r_lay)
            3'd1: begin
                w_idx_a[0] = 3'd0; w_idx_b[0] = 3'd3;
                w_idx_a[1] = 3'd1; w_idx_b[1] = 3'd2;
                w_idx_a[2] = 3'd4; w_idx_b[2] = 3'd7;
                w_idx_a[3] = 3'd5; w_idx_b[3] = 3'd6;
            end
            3'd3: begin
                w_idx_a[0] = 3'd0; w_idx_b[0] = 3'd7;
                w_idx_a[1] = 3'd1; w_idx_b[1] = 3'd6;
                w_idx_a[2] = 3'd2; w_idx_b[2] = 3'd5;
                w_idx_a[3] = 3'd3; w_idx_b[3] = 3'd4;
            end
            3'd4: begin
                w_idx_a[0] = 3'd0; w_idx_b[0] = 3'd2;
                w_idx_a[1] = 3'd1; w_idx_b[1] = 3'd3;
                w_idx_a[2] = 3'd4; w_idx_b[2] = 3'd6;
                w_idx_a[3] = 3'd5; w_idx_b[3] = 3'd7;
            end
            default: ;
        endcase
    end

    // Pairs within one layer are disjoint, so the four exchanges never collide.
    // Strict compare leaves equal values where they are.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_sorted[i] = r_data[i];
        end
        for (int k = 0; k < 4; k++) begin
            if (r_data[w_idx_a[k]] > r_data[w_idx_b[k]]) begin
                w_sorted[w_idx_a[k]] = r_data[w_idx_b[k]];
                w_sorted[w_idx_b[k]] = r_data[w_idx_a[k]];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_LOAD:  if (in_valid && (r_cnt == c_LAST_IDX)) w_state_next = S_SORT;
            S_SORT:  if (r_lay == c_LAST_LAY) w_state_next = S_DRAIN;
            S_DRAIN: if (out_ready && (r_cnt == c_LAST_IDX)) w_state_next = S_LOAD;
            default: w_state_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LOAD;
            r_cnt   <= 3'd0;
            r_lay   <= 3'd0;
            for (int i = 0; i < 8; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_LOAD: begin
                    if (in_valid) begin
                        r_data[r_cnt] <= in_data;
                        // 7 -> 0 wrap leaves the counter ready for DRAIN
                        r_cnt         <= r_cnt + 3'd1;
                        if (r_cnt == c_LAST_IDX) begin
                            r_lay <= 3'd0;
                        end
                    end
                end
                S_SORT: begin
                    for (int i = 0; i < 8; i++) begin
                        r_data[i] <= w_sorted[i];
                    end
                    r_lay <= r_lay + 3'd1;
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_rd_idx  = ASCEND ? r_cnt : (c_LAST_IDX - r_cnt);
    assign in_ready  = (r_state == S_LOAD);
    assign out_valid = (r_state == S_DRAIN);
    assign out_data  = out_valid ? r_data[w_rd_idx] : '0;
    assign out_last  = out_valid && (r_cnt == c_LAST_IDX);
    assign busy      = (r_state != S_LOAD) || (r_cnt != 3'd0);

endmodule
`default_nettype wire

// File: tb/tb_bitonic_sort_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bitonic_sort_seq
//  Purpose  : Self-checking bench for bitonic_sort_seq. An ascending and a
//             descending instance share all inputs; a negedge scoreboard
//             compares every output handshake and the handshake/busy timing.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bitonic_sort_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b0;

    logic       in_ready, out_valid, out_last, busy;
    logic [7:0] out_data;
    logic       d_in_ready, d_out_valid, d_out_last, d_busy;
    logic [7:0] d_out_data;

    bitonic_sort_seq #(.DATA_W(8), .ASCEND(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .out_last(out_last), .busy(busy)
    );

    bitonic_sort_seq #(.DATA_W(8), .ASCEND(1'b0)) dut_d (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(d_in_ready), .out_valid(d_out_valid), .out_data(d_out_data),
        .out_ready(out_ready), .out_last(d_out_last), .busy(d_busy)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] batch[$];
    logic [7:0] exp_a[$];
    logic [7:0] exp_d[$];
    logic [7:0] got_a[$];
    logic [7:0] got_d[$];
    int         sort_left = 0;
    int         ready_mode = 0;
    bit         mon_en = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_last = 1'b0;

    // Golden model: plain insertion sort of the accepted batch.
    function automatic void model_push();
        int a[8];
        for (int i = 0; i < 8; i++) a[i] = int'(batch[i]);
        for (int i = 1; i < 8; i++) begin
            int key = a[i];
            int j = i - 1;
            while (j >= 0 && a[j] > key) begin
                a[j + 1] = a[j];
                j--;
            end
            a[j + 1] = key;
        end
        for (int i = 0; i < 8; i++) begin
            exp_a.push_back(8'(a[i]));
            exp_d.push_back(8'(a[7 - i]));
        end
        batch.delete();
        sort_left = 6;
    endfunction

    // Scoreboard and protocol monitor
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            logic exp_busy, exp_rdy, exp_ov;
            exp_busy = (batch.size() != 0) || (exp_a.size() != 0);
            exp_rdy  = (exp_a.size() == 0);
            exp_ov   = (exp_a.size() != 0) && (sort_left == 0);
            checks++;
            if (busy !== exp_busy || d_busy !== exp_busy) begin
                errors++;
                $display("FAIL busy: got %b/%b expected %b", busy, d_busy, exp_busy);
            end
            checks++;
            if (in_ready !== exp_rdy || d_in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL in_ready: got %b/%b expected %b", in_ready, d_in_ready, exp_rdy);
            end
            checks++;
            if (out_valid !== exp_ov || d_out_valid !== exp_ov) begin
                errors++;
                $display("FAIL out_valid: got %b/%b expected %b", out_valid, d_out_valid, exp_ov);
            end
            if (sort_left > 0) sort_left--;
            if (!out_valid) begin
                checks++;
                if (out_data !== 8'h00 || out_last !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_outputs: got data=%h last=%b expected 00/0", out_data, out_last);
                end
            end
            if (out_valid && prev_stall) begin
                checks++;
                if (out_data !== prev_data || out_last !== prev_last) begin
                    errors++;
                    $display("FAIL stall_stable: got %h/%b expected %h/%b",
                             out_data, out_last, prev_data, prev_last);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (out_valid && out_ready && exp_a.size() != 0) begin
                logic [7:0] ea, ed;
                logic       el;
                ea = exp_a.pop_front();
                ed = exp_d.pop_front();
                el = (exp_a.size() == 0);
                got_a.push_back(out_data);
                got_d.push_back(d_out_data);
                checks++;
                if (out_data !== ea || d_out_data !== ed) begin
                    errors++;
                    $display("FAIL out_data: got asc=%h desc=%h expected asc=%h desc=%h",
                             out_data, d_out_data, ea, ed);
                end
                checks++;
                if (out_last !== el || d_out_last !== el) begin
                    errors++;
                    $display("FAIL out_last: got %b/%b expected %b", out_last, d_out_last, el);
                end
            end
            if (in_valid && in_ready) begin
                batch.push_back(in_data);
                if (batch.size() == 8) model_push();
            end
        end
    end

    // out_ready driver: 0 always ready, 1 fixed stall pattern, 2 random
    initial begin
        bit pat[6];
        int pi = 0;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0;
        pat[3] = 1'b1; pat[4] = 1'b0; pat[5] = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = pat[pi];
                    pi = (pi + 1) % 6;
                end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(input logic [7:0] v);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = v;
        for (int n = 0; n < 400 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout: got in_ready=0 for 400 cycles expected 1");
        end
    endtask

    task automatic send_batch(input logic [7:0] v[8], input int gap);
        for (int i = 0; i < 8; i++) begin
            tick(gap);
            send_beat(v[i]);
        end
    endtask

    // Also drops a held in_valid as soon as the last output handshake is done.
    task automatic wait_idle();
        bit idle = 1'b0;
        for (int n = 0; n < 400 && !idle; n++) begin
            @(posedge clk);
            #1;
            idle = (batch.size() == 0) && (exp_a.size() == 0);
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
        checks++;
        if (!idle) begin
            errors++;
            $display("FAIL drain_timeout: got batch still pending expected idle");
        end
    endtask

    task automatic check_got(input string name, input logic [7:0] ea[8], input logic [7:0] ed[8]);
        checks++;
        if (got_a.size() != 8 || got_d.size() != 8) begin
            errors++;
            $display("FAIL %s_count: got %0d/%0d beats expected 8", name, got_a.size(), got_d.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (got_a[i] !== ea[i] || got_d[i] !== ed[i]) begin
                    errors++;
                    $display("FAIL %s_beat%0d: got %h/%h expected %h/%h",
                             name, i, got_a[i], got_d[i], ea[i], ed[i]);
                    break;
                end
            end
        end
        got_a.delete();
        got_d.delete();
    endtask

    task automatic pulse_reset(input string name);
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00 ||
            out_last !== 1'b0 || busy !== 1'b0 || d_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s: got rdy=%b ov=%b data=%h last=%b busy=%b expected 1 0 00 0 0",
                     name, in_ready, out_valid, out_data, out_last, busy);
        end
        batch.delete(); exp_a.delete(); exp_d.delete();
        got_a.delete(); got_d.delete();
        sort_left  = 0;
        prev_stall = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        pulse_reset("reset_state");
        mon_en = 1'b1;
    endtask

    task automatic test_reverse_input();
        logic [7:0] v[8]  = '{8, 7, 6, 5, 4, 3, 2, 1};
        logic [7:0] ea[8] = '{1, 2, 3, 4, 5, 6, 7, 8};
        logic [7:0] ed[8] = '{8, 7, 6, 5, 4, 3, 2, 1};
        int lat = -1;
        ready_mode = 0;
        send_batch(v, 0);
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            @(negedge clk);
            if (out_valid) lat = c - 1;
        end
        checks++;
        if (lat != 6) begin
            errors++;
            $display("FAIL latency: got %0d edges expected 6", lat);
        end
        wait_idle();
        check_got("reverse", ea, ed);
    endtask

    task automatic test_duplicates();
        logic [7:0] v[8]  = '{5, 5, 0, 255, 5, 0, 255, 1};
        logic [7:0] ea[8] = '{0, 0, 1, 5, 5, 5, 255, 255};
        logic [7:0] ed[8] = '{255, 255, 5, 5, 5, 1, 0, 0};
        send_batch(v, 0);
        wait_idle();
        check_got("duplicates", ea, ed);
    endtask

    task automatic test_gaps_and_ignore();
        logic [7:0] v[8]  = '{9, 200, 3, 77, 3, 150, 0, 42};
        logic [7:0] ea[8] = '{0, 3, 3, 9, 42, 77, 150, 200};
        logic [7:0] ed[8] = '{200, 150, 77, 42, 9, 3, 3, 0};
        send_batch(v, 2);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        wait_idle();
        check_got("gaps", ea, ed);
    endtask

    task automatic test_stall();
        logic [7:0] v[8]  = '{17, 4, 99, 4, 250, 1, 64, 128};
        logic [7:0] ea[8] = '{1, 4, 4, 17, 64, 99, 128, 250};
        logic [7:0] ed[8] = '{250, 128, 99, 64, 17, 4, 4, 1};
        ready_mode = 1;
        send_batch(v, 0);
        wait_idle();
        ready_mode = 0;
        check_got("stall", ea, ed);
    endtask

    task automatic test_reset_mid();
        logic [7:0] v[8]  = '{3, 1, 2, 0, 7, 6, 5, 4};
        logic [7:0] ea[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
        logic [7:0] ed[8] = '{7, 6, 5, 4, 3, 2, 1, 0};
        logic [7:0] w[8]  = '{90, 80, 70, 60, 50, 40, 30, 20};
        bit reached = 1'b0;
        ready_mode = 1;
        send_batch(w, 0);
        for (int n = 0; n < 100 && !reached; n++) begin
            tick(1);
            reached = (got_a.size() >= 3);
        end
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL drain3_timeout: got %0d beats expected 3", got_a.size());
        end
        pulse_reset("reset_in_drain");
        ready_mode = 0;
        send_batch(v, 0);
        wait_idle();
        check_got("after_drain_reset", ea, ed);
        send_batch(w, 0);
        tick(2);
        pulse_reset("reset_in_sort");
        send_batch(v, 0);
        wait_idle();
        check_got("after_sort_reset", ea, ed);
    endtask

    task automatic test_back_to_back();
        ready_mode = 2;
        for (int b = 0; b < 1000; b++) begin
            for (int i = 0; i < 8; i++) begin
                logic [7:0] d;
                if ($urandom_range(0, 1) == 0) tick($urandom_range(1, 2));
                d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3))
                                                : 8'($urandom_range(0, 255));
                send_beat(d);
            end
        end
        wait_idle();
        ready_mode = 0;
        got_a.delete();
        got_d.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_reverse_input();
        test_duplicates();
        test_gaps_and_ignore();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        tick(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
